control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit register-bus CPU datapath.
- Sits directly upstream of the datapath: it reads IR from the datapath and drives every datapath control strobe (bus drivers, register enables, memory strobes, ALU select) once per step.
- Replaces the hand-sequenced control currently used in datapath benches.
- Implements fetch plus the execute sequences for load/store, load-immediate, R-format ALU ops, immediate ALU ops, nop and halt.

---
 rtl/cpu_pkg.sv | 101 ++++++++++
 rtl/control_decode.sv | 94 +++++++++
 rtl/control_sequencer.sv | 100 ++++++++++
 tb/tb_control_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-bus CPU control unit.
package cpu_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned ALU_W  = 4;

  // IR field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;
  localparam int unsigned C_MSB   = 18;
  localparam int unsigned C_LSB   = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'd7;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'd8;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'd9;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'd10;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'd11;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'd30;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'd31;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SHR = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SHL = 4'd5;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  // Datapath control strobe vector
  typedef struct packed {
    logic             pc_out;
    logic             zlow_out;
    logic             mdr_out;
    logic             ba_out;
    logic             c_out;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             r_in;
    logic             r_out;
    logic             mar_in;
    logic             mdr_in;
    logic             pc_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             inc_pc;
    logic             read;
    logic             write;
    logic [ALU_W-1:0] alu_op;
    logic             run;
  } ctrl_t;

  function automatic logic is_rfmt(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_ADD) && (opc <= OPC_SHL);
  endfunction

  function automatic logic is_imm(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_ADDI) && (opc <= OPC_ORI);
  endfunction

  // ld/ldi/st all form an address or constant as Rb(or 0) + C
  function automatic logic is_mem(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LD) || (opc == OPC_LDI) || (opc == OPC_ST);
  endfunction

  function automatic logic has_execute(input logic [OPC_W-1:0] opc);
    return (opc <= OPC_ORI);
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_SUB:           return ALU_SUB;
      OPC_AND, OPC_ANDI: return ALU_AND;
      OPC_OR,  OPC_ORI:  return ALU_OR;
      OPC_SHR:           return ALU_SHR;
      OPC_SHL:           return ALU_SHL;
      default:           return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational (state, opcode) -> datapath strobe decode.
module control_decode
  import cpu_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl_c
);

  // Strobes per step; anything not listed stays 0, so unknown opcodes never write.
  always_comb begin
    ctrl_c = '0;
    case (state)
      ST_T0: begin
        ctrl_c.run    = 1'b1;
        ctrl_c.pc_out = 1'b1;
        ctrl_c.mar_in = 1'b1;
        ctrl_c.inc_pc = 1'b1;
        ctrl_c.z_in   = 1'b1;
      end
      ST_T1: begin
        ctrl_c.run      = 1'b1;
        ctrl_c.zlow_out = 1'b1;
        ctrl_c.pc_in    = 1'b1;
        ctrl_c.read     = 1'b1;
        ctrl_c.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl_c.run     = 1'b1;
        ctrl_c.mdr_out = 1'b1;
        ctrl_c.ir_in   = 1'b1;
      end
      ST_T3: begin
        ctrl_c.run = 1'b1;
        if (is_rfmt(opcode) || is_imm(opcode)) begin
          ctrl_c.grb   = 1'b1;
          ctrl_c.r_out = 1'b1;
          ctrl_c.y_in  = 1'b1;
        end else if (is_mem(opcode)) begin
          ctrl_c.grb    = 1'b1;
          ctrl_c.ba_out = 1'b1;
          ctrl_c.y_in   = 1'b1;
        end
      end
      ST_T4: begin
        ctrl_c.run = 1'b1;
        if (is_rfmt(opcode)) begin
          ctrl_c.grc    = 1'b1;
          ctrl_c.r_out  = 1'b1;
          ctrl_c.z_in   = 1'b1;
          ctrl_c.alu_op = alu_sel(opcode);
        end else if (is_imm(opcode) || is_mem(opcode)) begin
          ctrl_c.c_out  = 1'b1;
          ctrl_c.z_in   = 1'b1;
          ctrl_c.alu_op = alu_sel(opcode);
        end
      end
      ST_T5: begin
        ctrl_c.run = 1'b1;
        if (opcode == OPC_LD || opcode == OPC_ST) begin
          ctrl_c.zlow_out = 1'b1;
          ctrl_c.mar_in   = 1'b1;
        end else if (is_rfmt(opcode) || is_imm(opcode) || opcode == OPC_LDI) begin
          ctrl_c.zlow_out = 1'b1;
          ctrl_c.gra      = 1'b1;
          ctrl_c.r_in     = 1'b1;
        end
      end
      ST_T6: begin
        ctrl_c.run = 1'b1;
        if (opcode == OPC_LD) begin
          ctrl_c.read   = 1'b1;
          ctrl_c.mdr_in = 1'b1;
        end else if (opcode == OPC_ST) begin
          ctrl_c.gra    = 1'b1;
          ctrl_c.r_out  = 1'b1;
          ctrl_c.mdr_in = 1'b1;
        end
      end
      ST_T7: begin
        ctrl_c.run = 1'b1;
        if (opcode == OPC_LD) begin
          ctrl_c.mdr_out = 1'b1;
          ctrl_c.gra     = 1'b1;
          ctrl_c.r_in    = 1'b1;
        end else if (opcode == OPC_ST) begin
          ctrl_c.write = 1'b1;
        end
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: step register, next-step logic and strobe fan-out.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned IR_WIDTH  = IR_W,
  parameter int unsigned OPC_WIDTH = OPC_W
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [IR_WIDTH-1:0] IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                BAout,
  output logic                Cout,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                MARin,
  output logic                MDRin,
  output logic                PCin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic [ALU_W-1:0]    ALU_op,
  output logic                Run
);

  state_t               state_q;
  state_t               state_d;
  logic [OPC_WIDTH-1:0] opcode;
  ctrl_t                ctrl_c;
  logic                 unused_ir_fields_c;

  assign opcode = IR[IR_WIDTH-1 -: OPC_WIDTH];
  // Register fields and C are consumed by the datapath select/encode logic, not here
  assign unused_ir_fields_c = ^IR[IR_WIDTH-OPC_WIDTH-1:0];

  // Step register; reset aborts any instruction in flight
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_RST;
    else          state_q <= state_d;
  end

  // Next step: fetch T0-T2, then opcode-dependent execute length
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        if (opcode == OPC_HALT)        state_d = ST_HALT;
        else if (has_execute(opcode))  state_d = ST_T4;
        else                           state_d = ST_T0;
      end
      ST_T4:  state_d = ST_T5;
      ST_T5:  state_d = (opcode == OPC_LD || opcode == OPC_ST) ? ST_T6 : ST_T0;
      ST_T6:  state_d = ST_T7;
      ST_T7:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl_c (ctrl_c)
  );

  assign PCout   = ctrl_c.pc_out;
  assign Zlowout = ctrl_c.zlow_out;
  assign MDRout  = ctrl_c.mdr_out;
  assign BAout   = ctrl_c.ba_out;
  assign Cout    = ctrl_c.c_out;
  assign Gra     = ctrl_c.gra;
  assign Grb     = ctrl_c.grb;
  assign Grc     = ctrl_c.grc;
  assign Rin     = ctrl_c.r_in;
  assign Rout    = ctrl_c.r_out;
  assign MARin   = ctrl_c.mar_in;
  assign MDRin   = ctrl_c.mdr_in;
  assign PCin    = ctrl_c.pc_in;
  assign IRin    = ctrl_c.ir_in;
  assign Yin     = ctrl_c.y_in;
  assign Zin     = ctrl_c.z_in;
  assign IncPC   = ctrl_c.inc_pc;
  assign Read    = ctrl_c.read;
  assign Write   = ctrl_c.write;
  assign ALU_op  = ctrl_c.alu_op;
  assign Run     = ctrl_c.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction strobe sequences.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset_n;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, BAout, Cout, Gra, Grb, Grc, Rin, Rout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, IncPC, Read, Write, Run;
  logic [3:0] ALU_op;

  int checks;
  int failures;

  // Observed vector layout: {PCout..Write, ALU_op[3:0], Run}
  localparam logic [23:0] M_PCOUT  = 24'h800000;
  localparam logic [23:0] M_ZLOW   = 24'h400000;
  localparam logic [23:0] M_MDROUT = 24'h200000;
  localparam logic [23:0] M_BAOUT  = 24'h100000;
  localparam logic [23:0] M_COUT   = 24'h080000;
  localparam logic [23:0] M_GRA    = 24'h040000;
  localparam logic [23:0] M_GRB    = 24'h020000;
  localparam logic [23:0] M_GRC    = 24'h010000;
  localparam logic [23:0] M_RIN    = 24'h008000;
  localparam logic [23:0] M_ROUT   = 24'h004000;
  localparam logic [23:0] M_MARIN  = 24'h002000;
  localparam logic [23:0] M_MDRIN  = 24'h001000;
  localparam logic [23:0] M_PCIN   = 24'h000800;
  localparam logic [23:0] M_IRIN   = 24'h000400;
  localparam logic [23:0] M_YIN    = 24'h000200;
  localparam logic [23:0] M_ZIN    = 24'h000100;
  localparam logic [23:0] M_INCPC  = 24'h000080;
  localparam logic [23:0] M_READ   = 24'h000040;
  localparam logic [23:0] M_WRITE  = 24'h000020;
  localparam logic [23:0] M_RUN    = 24'h000001;
  localparam logic [23:0] A_SUB    = 24'h000002;
  localparam logic [23:0] A_AND    = 24'h000004;
  localparam logic [23:0] A_OR     = 24'h000006;

  localparam logic [23:0] E_F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [23:0] E_F1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [23:0] E_F2 = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [23:0] E_T3_REG = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [23:0] E_T3_BA  = M_GRB | M_BAOUT | M_YIN | M_RUN;
  localparam logic [23:0] E_T4_C   = M_COUT | M_ZIN | M_RUN;
  localparam logic [23:0] E_WB     = M_ZLOW | M_GRA | M_RIN | M_RUN;
  localparam logic [23:0] E_T5_MAR = M_ZLOW | M_MARIN | M_RUN;

  control_sequencer dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .IR      (IR),
    .PCout   (PCout),
    .Zlowout (Zlowout),
    .MDRout  (MDRout),
    .BAout   (BAout),
    .Cout    (Cout),
    .Gra     (Gra),
    .Grb     (Grb),
    .Grc     (Grc),
    .Rin     (Rin),
    .Rout    (Rout),
    .MARin   (MARin),
    .MDRin   (MDRin),
    .PCin    (PCin),
    .IRin    (IRin),
    .Yin     (Yin),
    .Zin     (Zin),
    .IncPC   (IncPC),
    .Read    (Read),
    .Write   (Write),
    .ALU_op  (ALU_op),
    .Run     (Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [23:0] obs();
    return {PCout, Zlowout, MDRout, BAout, Cout, Gra, Grb, Grc, Rin, Rout,
            MARin, MDRin, PCin, IRin, Yin, Zin, IncPC, Read, Write, ALU_op, Run};
  endfunction

  // Hold reset across one rising edge with IR loaded, release on a falling edge
  task automatic apply_reset(input logic [31:0] ir);
    @(negedge Clock);
    Reset_n = 1'b0;
    IR      = ir;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    @(negedge Clock);
    Reset_n = 1'b0;
    IR      = 32'h28918000;
    #1;
    got = obs();
    checks++;
    if (got !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", got, 24'h0);
    end
    repeat (2) @(negedge Clock);
    got = obs();
    checks++;
    if (got !== 24'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", got, 24'h0);
    end
  endtask

  task automatic test_r_format();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, E_T3_REG, M_GRC | M_ROUT | M_ZIN | A_AND | M_RUN,
              E_WB, E_F0};
    apply_reset(32'h28918000);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL and_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_immediate();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, E_T3_REG, E_T4_C, E_WB, E_F0};
    apply_reset(32'h491FFFFB);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL addi_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, E_T3_BA, E_T4_C, E_T5_MAR,
              M_READ | M_MDRIN | M_RUN, M_MDROUT | M_GRA | M_RIN | M_RUN, E_F0};
    apply_reset(32'h00800065);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL ld_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, E_T3_BA, E_T4_C, E_T5_MAR,
              M_GRA | M_ROUT | M_MDRIN | M_RUN, M_WRITE | M_RUN, E_F0};
    apply_reset(32'h11080087);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL st_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, M_RUN};
    apply_reset(32'hF8000000);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL halt_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== 24'h0) begin
        failures++;
        $display("FAIL halt_idle%0d: got %h expected %h", c, got, 24'h0);
      end
    end
    apply_reset(32'hF8000000);
    @(negedge Clock);
    got = obs();
    checks++;
    if (got !== E_F0) begin
      failures++;
      $display("FAIL halt_restart: got %h expected %h", got, E_F0);
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, E_T3_REG, M_GRC | M_ROUT | M_ZIN | M_RUN};
    apply_reset(32'h18918000);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL add_pre_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    #1 Reset_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== 24'h0) begin
      failures++;
      $display("FAIL midreset_async: got %h expected %h", got, 24'h0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== 24'h0) begin
        failures++;
        $display("FAIL midreset_hold%0d: got %h expected %h (Rin=%b)", c, got, 24'h0, Rin);
      end
    end
    Reset_n = 1'b1;
    @(negedge Clock);
    got = obs();
    checks++;
    if (got !== E_F0) begin
      failures++;
      $display("FAIL midreset_restart: got %h expected %h", got, E_F0);
    end
  endtask

  task automatic test_illegal();
    logic [23:0] exp_q [$];
    logic [23:0] got;
    exp_q = '{E_F0, E_F1, E_F2, M_RUN, E_F0, E_F1};
    apply_reset(32'h78000000);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL illegal_step%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  // sub followed by ori with no reset between; IR changes during the T0 step
  task automatic test_back_to_back();
    logic [23:0] exp_a [$];
    logic [23:0] exp_b [$];
    logic [23:0] got;
    exp_a = '{E_F0, E_F1, E_F2, E_T3_REG, M_GRC | M_ROUT | M_ZIN | A_SUB | M_RUN,
              E_WB, E_F0};
    exp_b = '{E_F1, E_F2, E_T3_REG, E_T4_C | A_OR, E_WB, E_F0};
    apply_reset(32'h20918000);
    foreach (exp_a[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_a[i]) begin
        failures++;
        $display("FAIL b2b_sub_step%0d: got %h expected %h", i, got, exp_a[i]);
      end
    end
    IR = 32'h58918000;
    foreach (exp_b[i]) begin
      @(negedge Clock);
      got = obs();
      checks++;
      if (got !== exp_b[i]) begin
        failures++;
        $display("FAIL b2b_ori_step%0d: got %h expected %h", i, got, exp_b[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    IR       = 32'h0;
    test_reset();
    test_r_format();
    test_immediate();
    test_load();
    test_store();
    test_halt();
    test_mid_reset();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
